// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
//   state_t     : controller FSM states (exported on the debug port)
//   SZ_B/H/W    : access size codes carried on me_size
//   STALL_REQ   : level driven on *_stall_req while an access is pending
//   size_bytes(): size code -> number of bytes moved (1, 2 or 4)
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_RD   = 3'd1,
      ME_RD   = 3'd2,
      ME_WR   = 3'd3,
      DONE_IF = 3'd4,
      DONE_ME = 3'd5
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic STALL_REQ = 1'b1;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. The IF and MEM stages share one 8-bit
// synchronous RAM port; MEM wins arbitration in IDLE, and a running
// transaction always runs to completion (only an IF fetch may be aborted,
// by its requester dropping if_req).
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   if_req/if_addr           fetch request (level) and address
//   if_done/if_inst          one-cycle pulse with the fetched little-endian word
//   me_req/me_we/me_size     data access request, 1=store, size code
//   me_addr/me_wdata         data address and store data
//   me_done/me_rdata         one-cycle pulse with zero-extended load data
//   if_stall_req/me_stall_req  held while the stage's access is outstanding
//   mem_a/mem_dout/mem_wr    RAM byte address, write byte, write enable
//   mem_din                  RAM read byte, valid one cycle after mem_a
//   dbg_state_o              current FSM state
// Handshake: a requester holds its req level until it sees the done pulse and
// changes req in the following cycle; the DONE cycle never accepts, so the
// following IDLE cycle sees the updated request.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              me_req,
   input  logic              me_we,
   input  logic [1:0]        me_size,
   input  logic [ADDR_W-1:0] me_addr,
   input  logic [31:0]       me_wdata,
   output logic              me_done,
   output logic [31:0]       me_rdata,
   output logic              if_stall_req,
   output logic              me_stall_req,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic [7:0]        mem_din,
   output state_t            dbg_state_o
);

   state_t            state_q;
   logic [2:0]        cnt_q;     // cycles spent in the current access state
   logic [2:0]        n_q;       // bytes in the current access
   logic [31:0]       wdata_q;   // remaining store bytes, next byte in [7:0]
   logic [31:0]       asm_q;     // read assembly register
   logic [31:0]       asm_d;
   logic [ADDR_W-1:0] mem_a_q;
   logic [7:0]        mem_dout_q;
   logic              mem_wr_q;
   logic              if_done_q;
   logic              me_done_q;
   logic [31:0]       if_inst_q;
   logic [31:0]       me_rdata_q;
   logic [1:0]        byte_idx;

   // In a read state, cycle cnt sees the byte addressed during cycle cnt-1,
   // so byte (cnt-1) lands in the assembly register.
   always_comb begin
      byte_idx = cnt_q[1:0] - 2'd1;
      asm_d    = asm_q;
      if (cnt_q != 3'd0) begin
         asm_d[{byte_idx, 3'b000} +: 8] = mem_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         n_q        <= 3'd0;
         wdata_q    <= 32'd0;
         asm_q      <= 32'd0;
         mem_a_q    <= '0;
         mem_dout_q <= 8'd0;
         mem_wr_q   <= 1'b0;
         if_done_q  <= 1'b0;
         me_done_q  <= 1'b0;
         if_inst_q  <= 32'd0;
         me_rdata_q <= 32'd0;
      end else begin
         if_done_q <= 1'b0;
         me_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= 3'd0;
               asm_q <= 32'd0;
               if (me_req) begin
                  n_q     <= size_bytes(me_size);
                  mem_a_q <= me_addr;
                  if (me_we) begin
                     state_q    <= ME_WR;
                     mem_wr_q   <= 1'b1;
                     mem_dout_q <= me_wdata[7:0];
                     wdata_q    <= me_wdata >> 8;
                  end else begin
                     state_q <= ME_RD;
                  end
               end else if (if_req) begin
                  state_q <= IF_RD;
                  n_q     <= 3'd4;
                  mem_a_q <= if_addr;
               end
            end
            IF_RD, ME_RD: begin
               if (state_q == IF_RD && !if_req) begin
                  // Fetch flushed: drop it, leave if_inst and mem_a as they are.
                  state_q <= IDLE;
               end else begin
                  asm_q <= asm_d;
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q + 3'd1 < n_q) begin
                     mem_a_q <= mem_a_q + 1'b1;
                  end
                  if (cnt_q == n_q) begin
                     if (state_q == IF_RD) begin
                        state_q   <= DONE_IF;
                        if_done_q <= 1'b1;
                        if_inst_q <= asm_d;
                     end else begin
                        state_q    <= DONE_ME;
                        me_done_q  <= 1'b1;
                        me_rdata_q <= asm_d;
                     end
                  end
               end
            end
            ME_WR: begin
               // me_req is ignored here so a store is never left half-written.
               if (cnt_q + 3'd1 < n_q) begin
                  cnt_q      <= cnt_q + 3'd1;
                  mem_a_q    <= mem_a_q + 1'b1;
                  mem_dout_q <= wdata_q[7:0];
                  wdata_q    <= wdata_q >> 8;
               end else begin
                  mem_wr_q  <= 1'b0;
                  state_q   <= DONE_ME;
                  me_done_q <= 1'b1;
               end
            end
            DONE_IF, DONE_ME: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Write enable is cut the moment reset is asserted so a reset mid-store
   // commits no further bytes.
   assign mem_wr       = mem_wr_q & ~rst;
   assign mem_a        = mem_a_q;
   assign mem_dout     = mem_dout_q;
   assign if_done      = if_done_q;
   assign me_done      = me_done_q;
   assign if_inst      = if_inst_q;
   assign me_rdata     = me_rdata_q;
   assign if_stall_req = (~rst & if_req & ~if_done_q) ? STALL_REQ : ~STALL_REQ;
   assign me_stall_req = (~rst & me_req & ~me_done_q) ? STALL_REQ : ~STALL_REQ;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        me_req;
   logic        me_we;
   logic [1:0]  me_size;
   logic [31:0] me_addr;
   logic [31:0] me_wdata;
   logic        me_done;
   logic [31:0] me_rdata;
   logic        if_stall_req;
   logic        me_stall_req;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   state_t      dbg_state;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .me_req(me_req), .me_we(me_we), .me_size(me_size), .me_addr(me_addr),
      .me_wdata(me_wdata), .me_done(me_done), .me_rdata(me_rdata),
      .if_stall_req(if_stall_req), .me_stall_req(me_stall_req),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM attached to the port (256 bytes, address aliased on mem_a[7:0])
   logic [7:0] ram [0:255];
   logic       pre_we;
   logic [7:0] pre_a;
   logic [7:0] pre_d;
   always @(posedge clk) begin
      if (pre_we) ram[pre_a] <= pre_d;
      else if (mem_wr) ram[mem_a[7:0]] <= mem_dout;
      mem_din <= ram[mem_a[7:0]];
   end

   // reference model: byte-addressed memory image and expected results
   logic [7:0]  ref_ram [0:255];
   logic [31:0] exp_q[$];
   logic [31:0] last_inst;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
      logic [31:0] v;
      v = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_ram[8'(addr + 32'(k))];
      return v;
   endfunction

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_mem_a"}, mem_a, 32'd0);
      chk({pfx, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
      chk({pfx, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
      chk({pfx, "_if_done"}, {31'd0, if_done}, 32'd0);
      chk({pfx, "_me_done"}, {31'd0, me_done}, 32'd0);
      chk({pfx, "_if_inst"}, if_inst, 32'd0);
      chk({pfx, "_me_rdata"}, me_rdata, 32'd0);
      chk({pfx, "_if_stall"}, {31'd0, if_stall_req}, 32'd0);
      chk({pfx, "_me_stall"}, {31'd0, me_stall_req}, 32'd0);
      chk({pfx, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
   endtask

   // One isolated access, started #1 after a rising edge with the DUT idle.
   // Cycle 0 is the request cycle; bytes go out in cycles 1..n; done arrives
   // at n+2 for reads and n+1 for stores. Returns #1 after the edge following done.
   task automatic run_access(input bit is_if, input bit we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata);
      int          n;
      int          done_c;
      bit          store;
      logic [31:0] got;
      logic [31:0] exp;
      logic        exp_wr;
      store  = !is_if && we;
      n      = is_if ? 4 : nbytes(size);
      done_c = store ? n + 1 : n + 2;
      if (!store) exp_q.push_back(ref_read(addr, n));
      if (is_if) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         me_req = 1'b1; me_we = we; me_size = size; me_addr = addr; me_wdata = wdata;
      end
      for (int c = 0; c <= done_c; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= n) chk("mem_a", mem_a, addr + 32'(c - 1));
         exp_wr = store && c >= 1 && c <= n;
         chk("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
         if (exp_wr) chk("mem_dout", {24'd0, mem_dout}, {24'd0, wdata[8*(c-1) +: 8]});
         if (is_if) begin
            chk("if_done", {31'd0, if_done}, {31'd0, c == done_c});
            chk("if_stall", {31'd0, if_stall_req}, {31'd0, c != done_c});
         end else begin
            chk("me_done", {31'd0, me_done}, {31'd0, c == done_c});
            chk("me_stall", {31'd0, me_stall_req}, {31'd0, c != done_c});
         end
         if (c == done_c && !store) begin
            got = is_if ? if_inst : me_rdata;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            chk(is_if ? "if_inst" : "me_rdata", got, exp);
            if (is_if) last_inst = exp;
         end
         @(posedge clk); #1;
      end
      if (store) begin
         for (int k = 0; k < n; k++) ref_ram[8'(addr + 32'(k))] = wdata[8*k +: 8];
      end
      if_req = 1'b0;
      me_req = 1'b0;
   endtask

   // if_req and me_req raised together: MEM word load first, then the fetch.
   task automatic both_req(input logic [31:0] ma, input logic [31:0] ia);
      exp_q.push_back(ref_read(ma, 4));
      exp_q.push_back(ref_read(ia, 4));
      me_req = 1'b1; me_we = 1'b0; me_size = SZ_W; me_addr = ma;
      if_req = 1'b1; if_addr = ia;
      for (int c = 0; c <= 13; c++) begin
         if (c == 7) me_req = 1'b0;
         @(negedge clk);
         if (c >= 1 && c <= 4) chk("both_mem_a_me", mem_a, ma + 32'(c - 1));
         if (c >= 8 && c <= 11) chk("both_mem_a_if", mem_a, ia + 32'(c - 8));
         chk("both_mem_wr", {31'd0, mem_wr}, 32'd0);
         chk("both_me_done", {31'd0, me_done}, {31'd0, c == 6});
         chk("both_if_done", {31'd0, if_done}, {31'd0, c == 13});
         chk("both_if_stall", {31'd0, if_stall_req}, {31'd0, c != 13});
         chk("both_me_stall", {31'd0, me_stall_req}, {31'd0, c < 6});
         if (c == 6) chk("both_me_rdata", me_rdata, exp_q.pop_front());
         if (c == 13) begin
            last_inst = exp_q.pop_front();
            chk("both_if_inst", if_inst, last_inst);
         end
         @(posedge clk); #1;
      end
      if_req = 1'b0;
   endtask

   // Fetch flushed during its third cycle.
   task automatic if_abort(input logic [31:0] ia);
      if_req = 1'b1; if_addr = ia;
      for (int c = 0; c <= 7; c++) begin
         if (c == 2) if_req = 1'b0;
         @(negedge clk);
         chk("abort_if_done", {31'd0, if_done}, 32'd0);
         chk("abort_mem_wr", {31'd0, mem_wr}, 32'd0);
         chk("abort_if_inst", if_inst, last_inst);
         chk("abort_if_stall", {31'd0, if_stall_req}, {31'd0, c < 2});
         if (c == 3) chk("abort_state", {29'd0, dbg_state}, {29'd0, IDLE});
         if (c >= 2) chk("abort_mem_a_hold", mem_a, ia + 32'd1);
         @(posedge clk); #1;
      end
   endtask

   // Reset raised in the third cycle of a word store.
   task automatic store_reset(input logic [31:0] a, input logic [31:0] wd);
      me_req = 1'b1; me_we = 1'b1; me_size = SZ_W; me_addr = a; me_wdata = wd;
      @(negedge clk);
      chk("rs_me_stall", {31'd0, me_stall_req}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rs_mem_wr_b0", {31'd0, mem_wr}, 32'd1);
      chk("rs_mem_dout_b0", {24'd0, mem_dout}, {24'd0, wd[7:0]});
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rs_mem_wr_in_rst", {31'd0, mem_wr}, 32'd0);
      chk("rs_me_stall_in_rst", {31'd0, me_stall_req}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      me_req = 1'b0;
      @(negedge clk);
      check_all_zero("after_rst");
      @(posedge clk); #1;
      ref_ram[a[7:0]] = wd[7:0];
      last_inst = 32'd0;
   endtask

   initial begin
      int          kind;
      logic [31:0] a;
      logic [1:0]  sz;
      n_checks = 0;
      n_pass   = 0;
      last_inst = 32'd0;
      rst = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      me_req = 1'b0; me_we = 1'b0; me_size = 2'b00; me_addr = 32'd0; me_wdata = 32'd0;
      pre_we = 1'b1; pre_a = 8'd0; pre_d = 8'd0;
      for (int i = 0; i < 256; i++) begin
         pre_a = 8'(i);
         case (i)
            0:       pre_d = 8'h13;
            1:       pre_d = 8'h05;
            2, 3:    pre_d = 8'h00;
            default: pre_d = 8'($urandom_range(0, 255));
         endcase
         ref_ram[i] = pre_d;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;

      // requests present during reset must not raise stall
      if_req = 1'b1; me_req = 1'b1;
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      if_req = 1'b0; me_req = 1'b0; rst = 1'b0;
      @(posedge clk); #1;

      // directed cases
      run_access(1'b1, 1'b0, SZ_W, 32'h0000_1000, 32'd0);
      chk("dir_if_inst", if_inst, 32'h0000_0513);
      run_access(1'b0, 1'b1, SZ_W, 32'h0000_0020, 32'hDEAD_BEEF);
      run_access(1'b0, 1'b0, SZ_B, 32'h0000_0021, 32'd0);
      chk("dir_ld_byte", me_rdata, 32'h0000_00BE);
      run_access(1'b0, 1'b0, SZ_H, 32'h0000_0022, 32'd0);
      chk("dir_ld_half", me_rdata, 32'h0000_DEAD);
      both_req(32'h0000_0020, 32'h0000_1000);
      chk("dir_both_rdata", me_rdata, 32'hDEAD_BEEF);
      if_abort(32'h0000_0080);
      store_reset(32'h0000_0040, 32'h1122_3344);
      run_access(1'b0, 1'b0, SZ_W, 32'h0000_0040, 32'd0);
      run_access(1'b0, 1'b0, SZ_W, 32'hFFFF_FFFE, 32'd0);
      run_access(1'b0, 1'b1, SZ_H, 32'hFFFF_FFFF, 32'hCAFE_A55A);
      run_access(1'b1, 1'b0, SZ_W, 32'hFFFF_FFFD, 32'd0);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 3);
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                         : 32'($urandom_range(0, 1023));
         sz = 2'($urandom_range(0, 3));
         case (kind)
            0:       run_access(1'b1, 1'b0, SZ_W, a, 32'd0);
            1:       run_access(1'b0, 1'b1, sz, a, $urandom);
            default: run_access(1'b0, 1'b0, sz, a, 32'd0);
         endcase
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
